mem_access_sequencer: RTL and testbench

//  Multicycle sequencer between the control unit and the 64-bit data memory.

---
 rtl/mem_access_sequencer_if.sv | 26 ++
 rtl/mem_access_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// rtl/mem_access_sequencer_if.sv - request/response and data-memory signals of the memory access sequencer
interface mem_access_sequencer_if;
    logic        req;
    logic        req_we;
    logic [1:0]  tam;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic [63:0] mem_rdata;

    modport slave (
        input  req, req_we, tam, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req, req_we, tam, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - multicycle sized load/store sequencer with read-modify-write partial stores
module mem_access_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_sequencer_if.slave bus
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    tam_q, tam_d;
    logic [2:0]    off_q, off_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          mem_we_q, mem_we_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [63:0]   mem_addr_q, mem_addr_d;
    logic [63:0]   mem_wdata_q, mem_wdata_d;

    logic          misaligned;
    logic          accept;
    logic          rd_last;
    logic [63:0]   lane;
    logic [63:0]   load_val;
    logic [63:0]   size_mask;
    logic [63:0]   merged;

    assign accept  = (state_q == S_IDLE) && bus.req;
    assign rd_last = (state_q == S_RD) && (cnt_q == '0);

    always_comb begin
        misaligned = 1'b0;
        unique case (bus.tam)
            2'b00:   misaligned = (bus.addr[2:0] != 3'b000);
            2'b01:   misaligned = (bus.addr[1:0] != 2'b00);
            2'b10:   misaligned = bus.addr[0];
            default: misaligned = 1'b0;
        endcase
    end

    // Memory data is little-endian: shift the addressed lane down to bit 0.
    always_comb begin
        lane      = bus.mem_rdata >> {off_q, 3'b000};
        load_val  = lane;
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        unique case (tam_q)
            2'b01: begin
                load_val  = {{32{lane[31]}}, lane[31:0]};
                size_mask = 64'h0000_0000_FFFF_FFFF;
            end
            2'b10: begin
                load_val  = {{48{lane[15]}}, lane[15:0]};
                size_mask = 64'h0000_0000_0000_FFFF;
            end
            2'b11: begin
                load_val  = {{56{lane[7]}}, lane[7:0]};
                size_mask = 64'h0000_0000_0000_00FF;
            end
            default: begin
                load_val  = lane;
                size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
        merged = (bus.mem_rdata & ~(size_mask << {off_q, 3'b000}))
               | (({32'h0, wdata_q} & size_mask) << {off_q, 3'b000});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            tam_q       <= 2'b00;
            off_q       <= 3'b000;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            tam_q       <= tam_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (misaligned) begin
                        state_d = S_DONE;
                    end else if (bus.req_we && (bus.tam == 2'b00)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = CW'(MEM_LAT - 1);
                    end
                end
            end
            S_RD: begin
                if (cnt_q == '0) begin
                    state_d = we_q ? S_WR : S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        we_d        = we_q;
        tam_d       = tam_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        mem_we_d    = (state_d == S_WR);
        if (accept) begin
            we_d       = bus.req_we;
            tam_d      = bus.tam;
            off_d      = bus.addr[2:0];
            wdata_d    = bus.wdata[31:0];
            err_d      = misaligned;
            mem_addr_d = {bus.addr[63:3], 3'b000};
            if (state_d == S_WR) begin
                mem_wdata_d = bus.wdata;
            end
        end
        if (rd_last) begin
            if (we_q) begin
                mem_wdata_d = merged;
            end else begin
                rdata_d = load_val;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - directed table-driven bench for mem_access_sequencer
module tb_mem_access_sequencer;
    localparam int L = 2;

    logic clk;
    logic rst_n;
    mem_access_sequencer_if bus_if ();

    mem_access_sequencer #(.MEM_LAT(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [63:0] pre_data;
    int          we_cnt;

    assign bus_if.mem_rdata = mem[bus_if.mem_addr[6:3]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (bus_if.mem_we)
            mem[bus_if.mem_addr[6:3]] <= bus_if.mem_wdata;
    end

    initial we_cnt = 0;
    always @(posedge clk) if (bus_if.mem_we) we_cnt <= we_cnt + 1;

    typedef struct {
        logic        we;
        logic [1:0]  tam;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] pre;
        int          lat;
        logic        err;
        logic [63:0] rdata;
        logic [63:0] mem_after;
        int          nwe;
    } vec_t;

    int n_tests;
    int n_fail;
    logic [63:0] last_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_idx  = a[6:3];
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int cyc;
        int we0;
        logic is_load;
        preload(v.addr, v.pre);
        we0 = we_cnt;
        bus_if.req    = 1'b1;
        bus_if.req_we = v.we;
        bus_if.tam    = v.tam;
        bus_if.addr   = v.addr;
        bus_if.wdata  = v.wdata;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus_if.req = 1'b0;
                check({name, " busy_c1"}, {63'd0, bus_if.busy}, 64'd1);
                check({name, " err_c1"}, {63'd0, bus_if.err}, {63'd0, v.err});
            end
        end while (!bus_if.done && cyc < 20);
        check({name, " latency"}, 64'(cyc), 64'(v.lat));
        check({name, " err"}, {63'd0, bus_if.err}, {63'd0, v.err});
        is_load = !v.we && !v.err;
        if (is_load) last_rdata = v.rdata;
        check({name, " rdata"}, bus_if.rdata, last_rdata);
        check({name, " mem_addr"}, bus_if.mem_addr, {v.addr[63:3], 3'b000});
        check({name, " we_pulses"}, 64'(we_cnt - we0), 64'(v.nwe));
        check({name, " mem"}, mem[v.addr[6:3]], v.mem_after);
        @(negedge clk);
        check({name, " idle"}, {62'd0, bus_if.busy, bus_if.done}, 64'd0);
    endtask

    vec_t vecs [12];

    initial begin
        int cyc;
        int we0;
        n_tests = 0;
        n_fail = 0;
        last_rdata = '0;
        pre_we = 1'b0;
        pre_idx = '0;
        pre_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus_if.req = 1'b0;
        bus_if.req_we = 1'b0;
        bus_if.tam = 2'b00;
        bus_if.addr = '0;
        bus_if.wdata = '0;

        //            we    tam    addr    wdata                   pre                     lat  err   rdata                   mem_after               nwe
        vecs[0]  = '{1'b1, 2'b00, 64'h10, 64'h1122334455667788, 64'h0,                  2,   1'b0, 64'h0,                  64'h1122334455667788, 1};
        vecs[1]  = '{1'b1, 2'b11, 64'h23, 64'hAB,               64'hFFFFFFFFFFFFFFFF, L+2, 1'b0, 64'h0,                  64'hFFFFFFFFABFFFFFF, 1};
        vecs[2]  = '{1'b0, 2'b10, 64'h0C, 64'h0,                64'h0000800000000000, L+1, 1'b0, 64'hFFFFFFFFFFFF8000, 64'h0000800000000000, 0};
        vecs[3]  = '{1'b1, 2'b01, 64'h32, 64'h55,               64'h0123456789ABCDEF, 1,   1'b1, 64'h0,                  64'h0123456789ABCDEF, 0};
        vecs[4]  = '{1'b0, 2'b01, 64'h40, 64'h0,                64'h1234567887654321, L+1, 1'b0, 64'hFFFFFFFF87654321, 64'h1234567887654321, 0};
        vecs[5]  = '{1'b0, 2'b11, 64'h47, 64'h0,                64'h7F11223344556677, L+1, 1'b0, 64'h000000000000007F, 64'h7F11223344556677, 0};
        vecs[6]  = '{1'b0, 2'b00, 64'h50, 64'h0,                64'hDEADBEEFCAFEF00D, L+1, 1'b0, 64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 0};
        vecs[7]  = '{1'b1, 2'b10, 64'h5E, 64'hFFFF1234,         64'h0,                 L+2, 1'b0, 64'h0,                  64'h1234000000000000, 1};
        vecs[8]  = '{1'b1, 2'b01, 64'h64, 64'hAAAABBBBCCCCDDDD, 64'h1111111111111111, L+2, 1'b0, 64'h0,                  64'hCCCCDDDD11111111, 1};
        vecs[9]  = '{1'b0, 2'b00, 64'h09, 64'h0,                64'h00000000000000AA, 1,   1'b1, 64'h0,                  64'h00000000000000AA, 0};
        vecs[10] = '{1'b0, 2'b10, 64'h11, 64'h0,                64'h00000000000000BB, 1,   1'b1, 64'h0,                  64'h00000000000000BB, 0};
        vecs[11] = '{1'b1, 2'b11, 64'h69, 64'h5A,               64'h0,                 L+2, 1'b0, 64'h0,                  64'h0000000000005A00, 1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {60'd0, bus_if.busy, bus_if.done, bus_if.err, bus_if.mem_we}, 64'd0);
        check("reset rdata", bus_if.rdata, 64'd0);
        check("reset mem_addr", bus_if.mem_addr, 64'd0);
        check("reset mem_wdata", bus_if.mem_wdata, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // req held high across a partial store: only one access, one write
        preload(64'h20, 64'hFFFFFFFFFFFFFFFF);
        we0 = we_cnt;
        bus_if.req = 1'b1;
        bus_if.req_we = 1'b1;
        bus_if.tam = 2'b11;
        bus_if.addr = 64'h23;
        bus_if.wdata = 64'hAB;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus_if.done && cyc < 20);
        check("held latency", 64'(cyc), 64'(L + 2));
        check("held mem_wdata", bus_if.mem_wdata, 64'hFFFFFFFFABFFFFFF);
        bus_if.req = 1'b0;
        repeat (2) @(negedge clk);
        check("held idle", {62'd0, bus_if.busy, bus_if.done}, 64'd0);
        check("held we_pulses", 64'(we_cnt - we0), 64'd1);

        // async reset in the middle of a partial-store read phase
        preload(64'h70, 64'h0123456789ABCDEF);
        we0 = we_cnt;
        bus_if.req = 1'b1;
        bus_if.req_we = 1'b1;
        bus_if.tam = 2'b10;
        bus_if.addr = 64'h72;
        bus_if.wdata = 64'hBEEF;
        @(negedge clk);
        bus_if.req = 1'b0;
        check("rst pre busy", {63'd0, bus_if.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst abort outputs", {60'd0, bus_if.busy, bus_if.done, bus_if.err, bus_if.mem_we}, 64'd0);
        check("rst abort mem_addr", bus_if.mem_addr, 64'd0);
        check("rst abort rdata", bus_if.rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (L + 3) @(negedge clk);
        check("rst no write", 64'(we_cnt - we0), 64'd0);
        check("rst mem intact", mem[4'hE], 64'h0123456789ABCDEF);
        last_rdata = '0;
        run_vec(vecs[6], "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
